dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req, input, 1 bit: CPU access request, sampled only when ready=1.
REQ-004 SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-006 SHALL have port uns, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port ready, output, 1 bit: block idle and accepting req.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1 bit: misaligned or illegal access, valid with done.
REQ-012 SHALL have port rdata, output, 32 bits: extended load result.
REQ-013 SHALL have port ram_we, output, 1 bit: write enable to ram.
REQ-014 SHALL have port ram_addr, output, 32 bits: word index to ram.
REQ-015 SHALL have port ram_d_in, output, 32 bits: write word to ram.
REQ-016 SHALL have port ram_d_out, input, 32 bits: read word from ram; combinational from ram_addr; ram writes on rising clk when ram_we=1.

Function
REQ-017 SHALL implement FSM states IDLE, RD, WR, DONE; ready=1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge with state=IDLE and req=1, latching we, size, uns, addr, wdata; later changes to these inputs SHALL have no effect on the accepted access.
REQ-019 SHALL ignore req whenever state is not IDLE (no queuing).
REQ-020 SHALL flag as error: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=00.
REQ-021 SHALL handle an error access as IDLE->DONE with err=1, perform no ram access (ram_we=0 throughout), and leave rdata unchanged.
REQ-022 SHALL sequence a load as IDLE->RD->DONE: in RD, ram_addr={2'b00,addr_q[31:2]}; at the RD->DONE edge, rdata SHALL be registered from ram_d_out.
REQ-023 SHALL sequence a word store as IDLE->WR->DONE, with ram_d_in=wdata_q and ram_we=1 for exactly the WR cycle.
REQ-024 SHALL sequence a byte/halfword store as IDLE->RD->WR->DONE (read-modify-write): in RD capture the word; in WR drive the merged word with only the addressed lanes replaced.
REQ-025 SHALL use little-endian lane mapping: byte k = bits[8k+7:8k] for addr[1:0]=k; half h = bits[16h+15:16h] for addr[1]=h.
REQ-026 SHALL, for byte/half loads, extract the addressed lane and sign- or zero-extend it to 32 bits per uns; word loads SHALL be returned unmodified.
REQ-027 SHALL use store data from the low byte/half of wdata_q.
REQ-028 SHALL assert done=1 for exactly the DONE cycle, then return to IDLE; err SHALL be 0 whenever done=0.
REQ-029 SHALL meet these latencies from the accept edge to the done-high cycle: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-030 SHALL decode ram_we directly from the state register, with no combinational path from req.
REQ-031 SHALL hold rdata until the next successful load completes.

Reset
REQ-032 SHALL, while rst_n=0, force state=IDLE, ready=1, done=0, err=0, ram_we=0, and rdata, ram_addr, ram_d_in to 0, taking effect immediately regardless of clk.
REQ-033 SHALL abort any access in progress when reset asserts mid-operation: no ram write may occur after rst_n falls, and no done pulse may follow.

Verification
REQ-034 Bench SHALL drive a word store then a word load: store addr=0x4, wdata=0x43214312; then load addr=0x4 -> ram word1=0x43214312, rdata=0x43214312, done 2 cycles after each accept.
REQ-035 Bench SHALL test byte store with RMW: with ram word1=0x43214312, store byte addr=0x6, wdata=0xAB -> word1=0x43AB4312, done 3 cycles after accept, exactly one ram_we cycle.
REQ-036 Bench SHALL test load extension: with word1=0x43AB4312, load byte addr=0x6 uns=0 -> 0xFFFFFFAB; uns=1 -> 0x000000AB; half addr=0x6 uns=0 -> 0x000043AB.
REQ-037 Bench SHALL test misalignment: load half addr=0x5, then store word addr=0x6, then size=11 -> each gives done=1, err=1 one cycle after accept, ram_we never asserted, rdata unchanged.
REQ-038 Bench SHALL test reset during a byte store: drop rst_n in the RD cycle -> ram_we=0, ram word unchanged, no done pulse, ready=1 after release.
REQ-039 Bench SHALL test a busy request: hold req=1 continuously -> the second access is accepted only on the edge after DONE (one idle/accept cycle), with no lost or duplicated accesses.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: aligns, extends and sequences CPU loads/stores
// onto a single-port word RAM, using read-modify-write for sub-word stores.
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_d_in,
  input  logic [31:0] ram_d_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        misal;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = (state_q == S_IDLE) & req;

  assign misal = (size == 2'b11)
               | ((size == 2'b01) & addr[0])
               | ((size == 2'b10) & (addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (misal)
            state_d = S_DONE;
          else if (we && (size == 2'b10))
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_DONE;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lane_b   = ram_d_out[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = addr_q[1] ? ram_d_out[31:16] : ram_d_out[15:0];
    load_ext = ram_d_out;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = ram_d_out;
    endcase
  end

  // Only the addressed lanes of the captured word are replaced
  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= we;
        size_q  <= size;
        uns_q   <= uns;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= misal;
      end
      if (state_q == S_RD) begin
        word_q <= ram_d_out;
        if (!we_q)
          rdata_q <= load_ext;
      end
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = done & err_q;
  assign rdata    = rdata_q;
  assign ram_we   = (state_q == S_WR);
  assign ram_addr = ((state_q == S_RD) || (state_q == S_WR))
                  ? {2'b00, addr_q[31:2]} : 32'd0;
  assign ram_d_in = ram_we ? merged : 32'd0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-array reference model, directed
// scenarios for alignment/RMW/reset/busy, then randomized accesses.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_d_in;
  logic [31:0] ram_d_out;

  logic [31:0] ram [16];
  logic [7:0]  mdl [64];
  logic [31:0] mrd;
  int          n_chk;
  int          n_err;

  dmem_access_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .size      (size),
    .uns       (uns),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_d_in  (ram_d_in),
    .ram_d_out (ram_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (ram_we) ram[ram_addr[3:0]] <= ram_d_in;

  assign ram_d_out = ram[ram_addr[3:0]];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int wi);
    return {mdl[4*wi+3], mdl[4*wi+2], mdl[4*wi+1], mdl[4*wi]};
  endfunction

  function automatic logic [31:0] mload(input logic [1:0] sz, input logic u,
                                        input int a);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 0;
    for (int k = 0; k < n; k++)
      v = v | (32'(mdl[(a + k) & 63]) << (8 * k));
    if (n < 4 && !u && v[8*n-1])
      v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic scramble();
    we    = 1'($urandom);
    size  = 2'($urandom);
    uns   = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input int a, input logic [31:0] wd);
    logic e;
    int   lat;
    int   nwe;
    int   exl;
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
        (sz == 2'b10 && a[1:0] != 2'b00);
    exl = e ? 1 : (!w ? 2 : (sz == 2'b10 ? 2 : 3));
    @(negedge clk);
    check("ready", 32'(ready), 32'd1);
    req = 1'b1; we = w; size = sz; uns = u;
    addr = 32'(a); wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    scramble();
    lat = 0;
    nwe = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ram_we) nwe++;
      if (done) begin
        lat = i;
        break;
      end
      check("err_nodone", 32'(err), 32'd0);
    end
    check("latency", 32'(lat), 32'(exl));
    check("err", 32'(err), 32'(e));
    check("ram_we_cycles", 32'(nwe), (!e && w) ? 32'd1 : 32'd0);
    if (!e && w)
      for (int k = 0; k < (1 << sz); k++)
        mdl[(a + k) & 63] = wd[8*k +: 8];
    if (!e && !w)
      mrd = mload(sz, u, a);
    check("rdata", rdata, mrd);
    if (!e && w)
      check("ram_word", ram[a[5:2]], mword(a[5:2]));
  endtask

  initial begin
    int ndone;
    n_chk = 0;
    n_err = 0;
    mrd   = 32'd0;
    for (int i = 0; i < 64; i++) mdl[i] = 8'd0;
    rst_n = 1'b0;
    req   = 1'b0;
    scramble();
    #3;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_d_in", ram_d_in, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // word store then word load
    access(1'b1, 2'b10, 1'b0, 4, 32'h43214312);
    check("w1_after_store", ram[1], 32'h43214312);
    access(1'b0, 2'b10, 1'b0, 4, 32'h0);
    check("w1_load", rdata, 32'h43214312);

    // byte RMW store and extension
    access(1'b1, 2'b00, 1'b0, 6, 32'h000000AB);
    check("w1_after_rmw", ram[1], 32'h43AB4312);
    access(1'b0, 2'b00, 1'b0, 6, 32'h0);
    check("lb_sext", rdata, 32'hFFFFFFAB);
    access(1'b0, 2'b00, 1'b1, 6, 32'h0);
    check("lbu_zext", rdata, 32'h000000AB);
    access(1'b0, 2'b01, 1'b0, 6, 32'h0);
    check("lh_sext", rdata, 32'h000043AB);

    // misaligned and illegal
    access(1'b0, 2'b01, 1'b0, 5, 32'h0);
    access(1'b1, 2'b10, 1'b0, 6, 32'h11111111);
    access(1'b0, 2'b11, 1'b0, 4, 32'h0);
    check("rdata_kept", rdata, 32'h000043AB);
    check("w1_kept", ram[1], 32'h43AB4312);

    // reset during the RD cycle of a byte store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0;
    addr = 32'd6; wdata = 32'h000000CD;
    @(posedge clk);
    #1;
    req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ram_we", 32'(ram_we), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mrd = 32'd0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_ready_after", 32'(ready), 32'd1);
    check("abort_w1", ram[1], 32'h43AB4312);
    check("abort_rdata", rdata, 32'd0);

    // back-to-back requests with req held high
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0;
    addr = 32'd8; wdata = 32'hCAFE1234;
    begin
      int lat;
      lat = 0;
      @(posedge clk);
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        check("busy_ready", 32'(ready), 32'(done ? 0 : (i == 1 ? 0 : 0)));
        if (done) begin
          lat = i;
          break;
        end
      end
      check("busy_lat1", 32'(lat), 32'd2);
      for (int k = 0; k < 4; k++) mdl[8 + k] = wdata[8*k +: 8];
      @(negedge clk);
      check("busy_idle_ready", 32'(ready), 32'd1);
      we = 1'b0;
      @(posedge clk);
      #1;
      req = 1'b0;
      scramble();
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (done) begin
          lat = i;
          break;
        end
      end
      check("busy_lat2", 32'(lat), 32'd2);
      mrd = mword(2);
      check("busy_rdata", rdata, mrd);
      check("busy_w2", ram[2], 32'hCAFE1234);
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check("busy_no_extra", 32'(ndone), 32'd0);
    end

    // fill RAM, then randomized traffic
    for (int wi = 0; wi < 16; wi++)
      access(1'b1, 2'b10, 1'b0, 4 * wi, $urandom);
    for (int n = 0; n < 80; n++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      access(1'($urandom), sz, 1'($urandom), int'($urandom_range(0, 63)),
             $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
